// File: rtl/xyz_result_packer.sv
// Packs per-sample x/y/z check results into 8-bit words with mismatch masks; push to out_valid is one cycle.
// Input stalls only on a full FIFO at a word boundary or while a flush waits for space; output is valid/ready.

module xyz_rp_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   level_nxt;

    assign rd_nxt    = rd_ptr + AW'(pop);
    assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Head is reloaded every edge so the output word always comes straight from a flop;
    // when the FIFO drains to the word being pushed, bypass the array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            if (level_nxt == '0) begin
                head_dat <= '0;
            end else if (level == (AW+1)'(pop)) begin
                head_dat <= push_dat;
            end else begin
                head_dat <= mem[rd_nxt];
            end
        end
    end
endmodule

module xyz_result_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   x,
    input  logic                   y,
    input  logic                   z,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [7:0]             out_err,
    output logic [3:0]             out_len,
    output logic [CNT_W-1:0]       err_count,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        FILLING    = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] err;
        logic [3:0] len;
    } word_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] asm_data;
    logic [7:0] asm_err;
    logic       full;
    logic       accept;
    logic       mism;
    logic       flush_go;
    logic       push;
    logic       pop;
    word_t      cur;
    word_t      head;

    assign full      = (level == LW'(DEPTH));
    assign in_ready  = !((bit_cnt == 3'd7 && full) || state == FLUSH_WAIT);
    assign accept    = in_valid & in_ready;
    assign mism      = z ^ (x | ~y);
    assign flush_go  = flush && (state == FILLING);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;

    // A sample accepted in the same cycle as a push becomes the last bit of the pushed word.
    always_comb begin
        cur.data = asm_data;
        cur.err  = asm_err;
        cur.len  = {1'b0, bit_cnt};
        if (accept) begin
            cur.data[bit_cnt] = z;
            cur.err[bit_cnt]  = mism;
            cur.len           = {1'b0, bit_cnt} + 4'd1;
        end
    end

    assign push = (state == FLUSH_WAIT) ? !full
                                        : ((accept && bit_cnt == 3'd7) || (flush_go && !full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            bit_cnt   <= '0;
            asm_data  <= '0;
            asm_err   <= '0;
            err_count <= '0;
        end else begin
            if (accept && mism && err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (push) begin
                state    <= EMPTY;
                bit_cnt  <= '0;
                asm_data <= '0;
                asm_err  <= '0;
            end else begin
                if (accept) begin
                    asm_data <= cur.data;
                    asm_err  <= cur.err;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                // flush_go without push means the FIFO is full: park until a slot frees
                if (flush_go) begin
                    state <= FLUSH_WAIT;
                end else if (accept) begin
                    state <= FILLING;
                end
            end
        end
    end

    xyz_rp_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (cur),
        .pop      (pop),
        .head_dat (head),
        .level    (level)
    );

    assign out_data = head.data;
    assign out_err  = head.err;
    assign out_len  = head.len;
endmodule

// File: doc/xyz_result_packer.md
XYZ_RESULT_PACKER -- requirements
Module: xyz_result_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of packed-word FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the mismatch counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; this polarity and synchronicity are fixed.
REQ-005 in_valid  input  1  sample (x, y, z) present.
REQ-006 in_ready  output  1  sample accepted this cycle when in_valid & in_ready.
REQ-007 x, y  input  1 each  operands driven into the x/y logic stage.
REQ-008 z  input  1  result returned by the x/y logic stage for the same x, y.
REQ-009 flush  input  1  one-cycle pulse requesting emission of a partial word.
REQ-010 out_valid  output  1  packed word available at FIFO head.
REQ-011 out_ready  input  1  consumer accepts head word when out_valid & out_ready.
REQ-012 out_data  output  8  packed z bits, first-accepted sample in bit 0.
REQ-013 out_err  output  8  per-bit mismatch mask aligned with out_data.
REQ-014 out_len  output  4  number of valid bits in word, 1..8; unused upper bits of out_data/out_err are 0.
REQ-015 err_count  output  CNT_W  total mismatches since reset, saturating.
REQ-016 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Expected value SHALL be exp = x | ~y; a sample mismatches when z != exp.
REQ-018 Accepted samples SHALL be written to assembly bit position bit_cnt (0..7); bit_cnt increments by 1 per accept.
REQ-019 Accept with bit_cnt==7 SHALL push {data, err, len=8} into FIFO in the same cycle and reset bit_cnt to 0 (wrap).
REQ-020 Assembly FSM states: EMPTY (bit_cnt==0), FILLING (bit_cnt 1..7), FLUSH_WAIT (flush pending, FIFO full).
REQ-021 in_ready SHALL be 0 when (bit_cnt==7 and FIFO full) or state==FLUSH_WAIT; otherwise 1; derived from registered state only, not from out_ready.
REQ-022 flush in EMPTY SHALL be ignored (no zero-length word pushed).
REQ-023 flush in FILLING with FIFO not full SHALL push partial word with len=bit_cnt next edge, return to EMPTY, in_ready held 1 that cycle but any sample accepted in the flush cycle is included as the last bit of the flushed word.
REQ-024 flush in FILLING with FIFO full SHALL enter FLUSH_WAIT; push occurs on the first edge after a pop frees an entry, then EMPTY.
REQ-025 flush while in FLUSH_WAIT SHALL be ignored.
REQ-026 FIFO push and pop in same cycle SHALL both occur; level unchanged; push into full FIFO SHALL never happen.
REQ-027 out_data/out_err/out_len SHALL be registered FIFO head; latency from completing accept to out_valid=1 is one cycle when FIFO was empty.
REQ-028 err_count SHALL increment by 1 on each accepted mismatching sample and hold at 2^CNT_W-1.
REQ-029 out_valid SHALL equal (level != 0); head stays stable while out_valid & ~out_ready.

Reset
REQ-030 rst_n low SHALL immediately clear bit_cnt, FIFO pointers, level, err_count, state=EMPTY, out_valid=0, out_data=0, out_err=0, out_len=0; in_ready=1 after release.
REQ-031 Reset mid-word or mid-FLUSH_WAIT SHALL discard partial and queued words; no word emitted after release until new samples.

Verification
REQ-032 8 accepts (x,y,z)=(1,0,1),(0,1,0),(0,0,1),(1,1,1) repeated twice, out_ready=1 -> one word out_data=0xDD, out_err=0x00, out_len=8, err_count=0.
REQ-033 3 accepts with z inverted from exp for (0,1) sample only at bit 1, then flush -> out_data bit1=1, out_err=0x02, out_len=3, err_count=1.
REQ-034 out_ready=0, stream 8*DEPTH+7 matching samples -> level=DEPTH, in_ready=0 at bit_cnt==7; one pop -> next accept pushes, level returns to DEPTH.
REQ-035 FIFO full, bit_cnt=2, flush -> FLUSH_WAIT, in_ready=0; pop -> partial word len=2 pushed next edge, state EMPTY.
REQ-036 err_count forced near saturation via 2^CNT_W+3 mismatches (CNT_W=4 build) -> err_count holds 15.
REQ-037 rst_n low for one cycle with bit_cnt=5 and level=2 -> all outputs zero, out_valid=0, next 8 samples produce exactly one word.
